// File: rtl/aes_pkg.sv
// Shared AES datapath types and helpers: byte/state typedefs, byte-lane
// extraction in FIPS-197 order (byte 0 is the MSB) and the SubBytes FSM encoding.
package aes_pkg;

  localparam int NBYTES = 16;

  typedef logic [7:0]          aes_byte_t;
  typedef logic [8*NBYTES-1:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  function automatic aes_byte_t get_byte(input aes_state_t s, input int i);
    return s[8*(NBYTES-1-i) +: 8];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: purely combinational lookup over all 256 inputs.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam aes_byte_t SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative SubBytes: accepts one 128-bit state, substitutes BYTES_PER_CYCLE bytes
// per cycle through shared S-box lanes, then holds the result until accepted downstream.
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_data,
  output logic                  busy
);

  localparam int         B        = BYTES_PER_CYCLE;
  localparam logic [3:0] LAST_IDX = 4'(NBYTES - B);
  localparam logic [3:0] STEP     = 4'(B);

  generate
    if (!(B == 1 || B == 2 || B == 4 || B == 8 || B == 16)) begin : g_bad_bpc
      $error("sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  fsm_e        fsm_q, fsm_d;
  aes_state_t  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;

  aes_byte_t         lane_in  [B];
  aes_byte_t         lane_out [B];
  aes_state_t        run_state;
  logic [NBYTES-1:0] byte_en;

  genvar gi;
  generate
    for (gi = 0; gi < B; gi++) begin : g_lane
      assign lane_in[gi] = get_byte(state_q, int'(idx_q) + gi);
      aes_sbox u_sbox (
        .in_byte  (lane_in[gi]),
        .out_byte (lane_out[gi])
      );
    end

    // idx is always a multiple of B, so byte gi belongs to lane gi%B of group gi-gi%B.
    for (gi = 0; gi < NBYTES; gi++) begin : g_byte
      localparam int         LANE      = gi % B;
      localparam logic [3:0] GROUP_IDX = 4'(gi - LANE);
      assign byte_en[gi] = (idx_q == GROUP_IDX);
      assign run_state[8*(NBYTES-1-gi) +: 8] =
        byte_en[gi] ? lane_out[LANE] : state_q[8*(NBYTES-1-gi) +: 8];
    end
  endgenerate

  assign in_ready  = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = state_q;
  assign busy      = busy_q;

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          state_d = in_data;
          idx_d   = 4'd0;
          fsm_d   = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        state_d = run_state;
        if (idx_q == LAST_IDX) begin
          idx_d       = 4'd0;
          fsm_d       = DONE;
          out_valid_d = 1'b1;
        end else begin
          idx_d = idx_q + STEP;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            state_d = in_data;
            idx_d   = 4'd0;
            fsm_d   = RUN;
          end else begin
            fsm_d  = IDLE;
            busy_d = 1'b0;
          end
        end
      end
      default: begin
        fsm_d       = IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      idx_q       <= 4'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule
